fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;

  // Wrapping increment; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, one-cycle memory request tracking,
// fetch queue and decode handshake with redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 3) begin : g_depth_check
    $error("fetch_unit: DEPTH must be at least 3");
  end

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            issue, push, pop;

  // Reserve a slot for every outstanding request so a returning word always fits.
  assign issue = ((int'(fifo_count) + int'(inflight_q)) < int'(DEPTH)) && !redirect_valid;
  assign push  = inflight_q && !redirect_valid;
  assign pop   = if_valid && if_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_entry = '{pc: inflight_pc_q, instr: imem_rd_data};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  assign imem_addr = fetch_pc_q;
  assign if_valid  = (fifo_count != '0);
  assign if_instr  = if_valid ? fifo_head.instr : '0;
  assign if_pc     = if_valid ? fifo_head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for the start-up stream plus
// hand-written back-pressure, redirect, PC wrap and async reset sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_valid2;

  logic [31:0] imem_addr, imem_rd_data, if_instr, if_pc;
  logic        if_valid;
  logic [31:0] imem_addr2, imem_rd_data2, if_instr2, if_pc2;
  logic        if_valid2;

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8),
    .DEPTH    (4)
  ) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr2),
    .imem_rd_data   (imem_rd_data2),
    .if_valid       (if_valid2),
    .if_ready       (if_ready),
    .if_instr       (if_instr2),
    .if_pc          (if_pc2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge clk) begin
    imem_rd_data  <= mem_word(imem_addr);
    imem_rd_data2 <= mem_word(imem_addr2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns into cycle 0 after reset release.
  task automatic do_reset();
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc2;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc_exp;
    int j;

    rst_n           = 1'b0;
    if_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    redirect_valid2 = 1'b0;

    // Start-up stream with if_ready high; dut_wrap shows the PC wrap past 0xFFFF_FFFC.
    tbl[0] = '{1'b1, 1'b0, 32'h0,  32'h0,         32'h00, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h0,  32'h0,         32'h04, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h0,  32'h1000_0000, 32'h08, 32'hFFFF_FFF8};
    tbl[3] = '{1'b1, 1'b1, 32'h4,  32'h1000_0001, 32'h0C, 32'hFFFF_FFFC};
    tbl[4] = '{1'b1, 1'b1, 32'h8,  32'h1000_0002, 32'h10, 32'h0000_0000};
    tbl[5] = '{1'b1, 1'b1, 32'hC,  32'h1000_0003, 32'h14, 32'h0000_0004};
    tbl[6] = '{1'b1, 1'b1, 32'h10, 32'h1000_0004, 32'h18, 32'h0000_0008};
    tbl[7] = '{1'b1, 1'b1, 32'h14, 32'h1000_0005, 32'h1C, 32'h0000_000C};

    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      if_ready = tbl[k].ready;
      check($sformatf("stream%0d valid", k), {31'b0, if_valid}, {31'b0, tbl[k].exp_valid});
      check($sformatf("stream%0d pc", k), if_pc, tbl[k].exp_pc);
      check($sformatf("stream%0d instr", k), if_instr, tbl[k].exp_instr);
      check($sformatf("stream%0d addr", k), imem_addr, tbl[k].exp_addr);
      check($sformatf("stream%0d wrap_pc", k), if_pc2, tbl[k].exp_pc2);
    end

    // Back-pressure: queue fills to 4 and issue stalls at 0x10.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      if_ready = 1'b0;
      if (c == 6 || c == 9) begin
        check($sformatf("bp c%0d count", c), 32'(dut.fifo_count), 32'd4);
        check($sformatf("bp c%0d addr", c), imem_addr, 32'h10);
      end
    end
    pc_exp = 32'h0;
    j = 0;
    while (j < 30 && pc_exp != 32'h20) begin
      next_cycle();
      if_ready = 1'b1;
      if (j == 1) check("bp release addr j1", imem_addr, 32'h10);
      if (j == 2) check("bp release addr j2", imem_addr, 32'h14);
      check($sformatf("bp drain valid j%0d", j), {31'b0, if_valid}, 32'd1);
      if (if_valid) begin
        check($sformatf("bp drain pc j%0d", j), if_pc, pc_exp);
        check($sformatf("bp drain instr j%0d", j), if_instr, mem_word(pc_exp));
        pc_exp += 32'h4;
      end
      j++;
    end
    check("bp drain complete", pc_exp, 32'h20);

    // Redirect with 3 queued entries and one in flight; low bits of target ignored.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      if_ready = 1'b0;
    end
    check("redir pre count", 32'(dut.fifo_count), 32'd3);
    check("redir pre inflight", {31'b0, dut.inflight_q}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    next_cycle();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    check("redir t1 valid", {31'b0, if_valid}, 32'd0);
    check("redir t1 addr", imem_addr, 32'h100);
    check("redir t1 count", 32'(dut.fifo_count), 32'd0);
    next_cycle();
    check("redir t2 valid", {31'b0, if_valid}, 32'd0);
    check("redir t2 addr", imem_addr, 32'h104);
    next_cycle();
    check("redir t3 valid", {31'b0, if_valid}, 32'd1);
    check("redir t3 pc", if_pc, 32'h100);
    check("redir t3 instr", if_instr, 32'h1000_0040);
    next_cycle();
    check("redir t4 pc", if_pc, 32'h104);

    // Redirect coinciding with a handshake, then back-to-back redirects.
    do_reset();
    if_ready = 1'b1;
    repeat (4) next_cycle();
    check("hs pre valid", {31'b0, if_valid}, 32'd1);
    check("hs pre pc", if_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    next_cycle();
    redirect_valid = 1'b0;
    check("hs t1 valid", {31'b0, if_valid}, 32'd0);
    check("hs t1 addr", imem_addr, 32'h200);
    next_cycle();
    check("hs t2 valid", {31'b0, if_valid}, 32'd0);
    next_cycle();
    check("hs t3 pc", if_pc, 32'h200);
    next_cycle();
    check("hs t4 pc", if_pc, 32'h204);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    next_cycle();
    redirect_pc = 32'h400;
    check("b2b first addr", imem_addr, 32'h300);
    next_cycle();
    redirect_valid = 1'b0;
    check("b2b second addr", imem_addr, 32'h400);
    check("b2b valid", {31'b0, if_valid}, 32'd0);
    next_cycle();
    check("b2b t2 valid", {31'b0, if_valid}, 32'd0);
    next_cycle();
    check("b2b t3 valid", {31'b0, if_valid}, 32'd1);
    check("b2b t3 pc", if_pc, 32'h400);

    // Asynchronous reset mid-cycle with a full queue.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) next_cycle();
      if_ready = 1'b0;
    end
    check("areset pre count", 32'(dut.fifo_count), 32'd4);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset valid", {31'b0, if_valid}, 32'd0);
    check("areset addr", imem_addr, 32'h0);
    check("areset count", 32'(dut.fifo_count), 32'd0);
    check("areset wrap addr", imem_addr2, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    if_ready = 1'b1;
    check("restart c0 addr", imem_addr, 32'h0);
    check("restart c0 valid", {31'b0, if_valid}, 32'd0);
    next_cycle();
    check("restart c1 valid", {31'b0, if_valid}, 32'd0);
    next_cycle();
    check("restart c2 valid", {31'b0, if_valid}, 32'd1);
    check("restart c2 pc", if_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
